// File: rtl/fan_speed_ctrl.sv
// Four-level thermal fan controller with hysteresis, debounce,
// ramped duty command, sensor timeout and invalid-code fault.
module fan_speed_ctrl #(
  parameter int SENSOR_W = 8,
  parameter int CRS_W    = 4,
  parameter int T_ON1    = 35,
  parameter int T_ON2    = 40,
  parameter int T_ON3    = 45,
  parameter int T_OFF1   = 25,
  parameter int T_OFF2   = 35,
  parameter int T_OFF3   = 40,
  parameter int DUTY1    = 4,
  parameter int DUTY2    = 6,
  parameter int DUTY3    = 8,
  parameter int DUTY_MAX = 15,
  parameter int DEB_N    = 3,
  parameter int RAMP_DIV = 4,
  parameter int TIMEOUT  = 1000
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       en,
  input  logic                       sensor_valid,
  input  logic signed [SENSOR_W-1:0] sensor,
  output logic [CRS_W-1:0]           crs_o,
  output logic [2:0]                 level_o,
  output logic                       fault_o,
  output logic                       ramping_o
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_L1    = 3'd1,
    S_L2    = 3'd2,
    S_L3    = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam int DW = $clog2(DEB_N + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic signed [SENSOR_W-1:0] ON1  = SENSOR_W'(T_ON1);
  localparam logic signed [SENSOR_W-1:0] ON2  = SENSOR_W'(T_ON2);
  localparam logic signed [SENSOR_W-1:0] ON3  = SENSOR_W'(T_ON3);
  localparam logic signed [SENSOR_W-1:0] OFF1 = SENSOR_W'(T_OFF1);
  localparam logic signed [SENSOR_W-1:0] OFF2 = SENSOR_W'(T_OFF2);
  localparam logic signed [SENSOR_W-1:0] OFF3 = SENSOR_W'(T_OFF3);
  localparam logic signed [SENSOR_W-1:0] BAD  =
    {1'b1, {(SENSOR_W-1){1'b0}}};

  localparam logic [CRS_W-1:0] D1   = CRS_W'(DUTY1);
  localparam logic [CRS_W-1:0] D2   = CRS_W'(DUTY2);
  localparam logic [CRS_W-1:0] D3   = CRS_W'(DUTY3);
  localparam logic [CRS_W-1:0] DMAX = CRS_W'(DUTY_MAX);

  state_t          level;
  logic            fault_q;
  logic [CRS_W-1:0] crs_q;
  logic [DW-1:0]   deb_cnt;
  logic            deb_up;
  logic [TW-1:0]   to_cnt;
  logic [PW-1:0]   presc;

  logic            up_c;
  logic            dn_c;
  logic            go_up;
  logic            cand;
  logic            commit;
  logic            bad_code;
  logic            tmo;
  logic            pulse;
  logic [DW-1:0]   deb_nxt;
  logic [CRS_W-1:0] lvl_tgt;
  logic [CRS_W-1:0] tgt;
  logic [CRS_W-1:0] crs_ramp;

  // Per-level threshold candidates and duty target
  always_comb begin
    up_c    = 1'b0;
    dn_c    = 1'b0;
    lvl_tgt = '0;
    unique case (level)
      S_OFF: begin
        up_c = sensor > ON1;
      end
      S_L1: begin
        up_c    = sensor > ON2;
        dn_c    = sensor < OFF1;
        lvl_tgt = D1;
      end
      S_L2: begin
        up_c    = sensor > ON3;
        dn_c    = sensor < OFF2;
        lvl_tgt = D2;
      end
      S_L3: begin
        dn_c    = sensor < OFF3;
        lvl_tgt = D3;
      end
      S_FAULT: begin
        lvl_tgt = DMAX;
      end
      default: ;
    endcase
  end

  // Debounce, fault detection and ramp step selection
  always_comb begin
    go_up    = up_c & ~dn_c;
    cand     = up_c | dn_c;
    deb_nxt  = (deb_cnt != '0 && deb_up == go_up)
             ? deb_cnt + 1'b1 : DW'(1);
    commit   = cand && (deb_nxt == DW'(DEB_N));
    bad_code = sensor_valid && (sensor == BAD);
    tmo      = !sensor_valid && (to_cnt == TW'(TIMEOUT - 1));
    pulse    = (presc == PW'(RAMP_DIV - 1));
    tgt      = en ? lvl_tgt : '0;
    crs_ramp = crs_q;
    if (pulse && crs_q < tgt)
      crs_ramp = crs_q + 1'b1;
    else if (pulse && crs_q > tgt)
      crs_ramp = crs_q - 1'b1;
  end

  // Level FSM, counters and duty register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level   <= S_OFF;
      fault_q <= 1'b0;
      crs_q   <= '0;
      deb_cnt <= '0;
      deb_up  <= 1'b0;
      to_cnt  <= '0;
      presc   <= '0;
    end else begin
      presc <= pulse ? '0 : presc + 1'b1;
      crs_q <= crs_ramp;
      if (!en) begin
        level   <= S_OFF;
        fault_q <= 1'b0;
        deb_cnt <= '0;
        to_cnt  <= '0;
      end else if (bad_code || tmo) begin
        level   <= S_FAULT;
        fault_q <= 1'b1;
        crs_q   <= DMAX;
        deb_cnt <= '0;
        to_cnt  <= '0;
      end else if (sensor_valid) begin
        to_cnt <= '0;
        if (level == S_FAULT) begin
          level   <= S_L3;
          fault_q <= 1'b0;
          deb_cnt <= '0;
        end else if (!cand) begin
          deb_cnt <= '0;
        end else if (commit) begin
          deb_cnt <= '0;
          level   <= go_up ? state_t'(level + 3'd1)
                           : state_t'(level - 3'd1);
        end else begin
          deb_cnt <= deb_nxt;
          deb_up  <= go_up;
        end
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  assign crs_o     = crs_q;
  assign level_o   = level;
  assign fault_o   = fault_q;
  assign ramping_o = (crs_q != tgt);

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Self-checking bench for fan_speed_ctrl: per-cycle reference
// model compare plus directed scenarios with literal expectations.
module tb_fan_speed_ctrl;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              en = 1'b0;
  logic              sensor_valid = 1'b0;
  logic signed [7:0] sensor = '0;
  logic [3:0]        crs_o;
  logic [2:0]        level_o;
  logic              fault_o;
  logic              ramping_o;

  int n_chk = 0;
  int n_err = 0;

  fan_speed_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .en           (en),
    .sensor_valid (sensor_valid),
    .sensor       (sensor),
    .crs_o        (crs_o),
    .level_o      (level_o),
    .fault_o      (fault_o),
    .ramping_o    (ramping_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_lvl = 0;
  int m_crs = 0;
  int m_run = 0;
  int m_dir = 0;
  int m_idle = 0;
  int m_tick = 0;

  int up_th [4] = '{35, 40, 45, 999};
  int dn_th [4] = '{-999, 25, 35, 40};
  int duty  [5] = '{0, 4, 6, 8, 15};

  function automatic int target(int lvl, logic e);
    return e ? duty[lvl] : 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model update on every clock edge
  always @(posedge clk or negedge rstn) begin : model
    int t;
    int s;
    int d;
    if (!rstn) begin
      m_lvl = 0; m_crs = 0; m_run = 0;
      m_dir = 0; m_idle = 0; m_tick = 0;
    end else begin
      t = target(m_lvl, en);
      if (m_tick % 4 == 3) begin
        if (m_crs < t) m_crs++;
        else if (m_crs > t) m_crs--;
      end
      m_tick++;
      s = int'(sensor);
      if (!en) begin
        m_lvl = 0; m_run = 0; m_idle = 0;
      end else if (sensor_valid && s == -128) begin
        m_lvl = 4; m_crs = 15; m_run = 0; m_idle = 0;
      end else if (sensor_valid) begin
        m_idle = 0;
        if (m_lvl == 4) begin
          m_lvl = 3; m_run = 0;
        end else begin
          d = 0;
          if (s < dn_th[m_lvl]) d = -1;
          else if (s > up_th[m_lvl]) d = 1;
          if (d == 0) m_run = 0;
          else if (d == m_dir && m_run > 0) m_run++;
          else begin m_run = 1; m_dir = d; end
          if (d != 0 && m_run == 3) begin
            m_lvl += d; m_run = 0;
          end
        end
      end else if (m_idle == 999) begin
        m_lvl = 4; m_crs = 15; m_idle = 0;
      end else begin
        m_idle++;
      end
    end
  end

  // Compare DUT outputs against the model every cycle
  always @(negedge clk) begin
    chk("crs", int'(crs_o), m_crs);
    chk("level", int'(level_o), m_lvl);
    chk("fault", int'(fault_o), int'(m_lvl == 4));
    chk("ramping", int'(ramping_o),
        int'(m_crs != target(m_lvl, en)));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_s(input int v);
    sensor = v[7:0];
  endtask

  task automatic pin(input string nm, input int lv, input int cr);
    chk({nm, "_lvl"}, int'(level_o), lv);
    chk({nm, "_crs"}, int'(crs_o), cr);
    chk({nm, "_mlvl"}, m_lvl, lv);
    chk({nm, "_mcrs"}, m_crs, cr);
  endtask

  int seq2 [6] = '{41, 41, 30, 41, 41, 41};

  initial begin
    // 1: OFF -> L1 after three samples, ramp 0 -> 4
    en = 1'b1;
    sensor_valid = 1'b1;
    set_s(36);
    #12 rstn = 1'b1;
    pin("rst", 0, 0);
    chk("rst_fault", int'(fault_o), 0);
    repeat (2) step();
    pin("t1_e2", 0, 0);
    step();
    pin("t1_e3", 1, 0);
    repeat (12) step();
    pin("t1_e15", 1, 3);
    chk("t1_ramp_on", int'(ramping_o), 1);
    step();
    pin("t1_e16", 1, 4);
    chk("t1_ramp_off", int'(ramping_o), 0);

    // 2: debounce restart in L1
    for (int i = 0; i < 6; i++) begin
      set_s(seq2[i]);
      step();
      if (i == 4) chk("t2_hold", int'(level_o), 1);
    end
    chk("t2_step", int'(level_o), 2);
    set_s(38);
    repeat (12) step();
    pin("t2_end", 2, 6);

    // 3: hysteresis band, then down to L1
    repeat (50) step();
    chk("t3_band", int'(level_o), 2);
    set_s(34);
    repeat (3) step();
    chk("t3_down", int'(level_o), 1);
    set_s(30);
    repeat (12) step();
    pin("t3_end", 1, 4);

    // 4: sensor timeout into FAULT and recovery to L3
    sensor_valid = 1'b0;
    repeat (999) step();
    pin("t4_pre", 1, 4);
    step();
    pin("t4_fault", 4, 15);
    chk("t4_fault_o", int'(fault_o), 1);
    sensor_valid = 1'b1;
    set_s(30);
    step();
    pin("t4_exit", 3, 15);
    chk("t4_fault_clr", int'(fault_o), 0);
    sensor_valid = 1'b0;
    repeat (40) step();
    pin("t4_end", 3, 8);

    // 5: invalid code fault, then disable ramps to 0
    en = 1'b0;
    step();
    chk("t5_off", int'(level_o), 0);
    en = 1'b1;
    sensor_valid = 1'b1;
    set_s(-128);
    step();
    pin("t5_bad", 4, 15);
    en = 1'b0;
    sensor_valid = 1'b0;
    step();
    chk("t5_dis_lvl", int'(level_o), 0);
    chk("t5_dis_flt", int'(fault_o), 0);
    repeat (62) step();
    pin("t5_end", 0, 0);

    // 6: asynchronous reset mid-ramp
    en = 1'b1;
    sensor_valid = 1'b1;
    set_s(41);
    for (int i = 0; i < 100 && crs_o != 4'd5; i++) step();
    pin("t6_mid", 2, 5);
    @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("t6_rst_crs", int'(crs_o), 0);
    chk("t6_rst_lvl", int'(level_o), 0);
    chk("t6_rst_flt", int'(fault_o), 0);
    chk("t6_rst_rmp", int'(ramping_o), 0);
    set_s(20);
    #5 rstn = 1'b1;
    repeat (20) step();
    pin("t6_end", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fan_speed_ctrl.md
Name: fan_speed_ctrl

Overview:
- Parametrised 4-level thermal fan controller with hysteresis: OFF, L1, L2, L3, plus a FAULT state.
- Adds sample-valid qualification, N-sample debounce, ramped duty output, sensor-timeout/invalid-code fault and an enable input.
- Sits between the temperature-sensor sampler and the fan PWM generator; crs_o is the PWM duty command.

Parameters:
SENSOR_W, 8, signed sensor width
CRS_W, 4, duty command width
T_ON1, 35, OFF->L1 threshold (strictly greater)
T_ON2, 40, L1->L2 threshold
T_ON3, 45, L2->L3 threshold
T_OFF1, 25, L1->OFF threshold (strictly less)
T_OFF2, 35, L2->L1 threshold
T_OFF3, 40, L3->L2 threshold
DUTY1, 4, L1 duty target
DUTY2, 6, L2 duty target
DUTY3, 8, L3 duty target
DUTY_MAX, 15, FAULT duty
DEB_N, 3, consecutive qualifying samples per step (>=1)
RAMP_DIV, 4, cycles per ramp step (>=1)
TIMEOUT, 1000, cycles without sensor_valid before FAULT (>=2)

Ports:
clk  in  1  clock
rstn  in  1  async active-low reset
en  in  1  controller enable
sensor_valid  in  1  sensor holds a new sample this cycle
sensor  in  SENSOR_W  signed temperature sample
crs_o  out  CRS_W  duty command
level_o  out  3  state code: 0 OFF, 1 L1, 2 L2, 3 L3, 4 FAULT
fault_o  out  1  high while in FAULT
ramping_o  out  1  high while crs_o != target

Behaviour:
- Reset: the design uses reset rstn, asynchronous, active-low, and clock clk. On reset: level OFF, crs_o 0, fault_o 0, ramping_o 0, debounce/timeout/prescaler counters 0.
- Thresholds use signed compares. Targets: OFF 0, L1 DUTY1, L2 DUTY2, L3 DUTY3, FAULT DUTY_MAX.
- Decisions happen only on cycles with sensor_valid=1. Per-state candidates:
  - OFF: up if s>T_ON1.
  - L1: up if s>T_ON2; down if s<T_OFF1.
  - L2: up if s>T_ON3; down if s<T_OFF2.
  - L3: down if s<T_OFF3.
  - If both up and down are true, down wins.
- Max one level step per transition. No skipping.
- Debounce:
  - A candidate direction increments deb_cnt.
  - A valid sample with no candidate, or the opposite direction, reloads deb_cnt to 0, or to 1 for a new direction.
  - The step commits on the clock edge of the DEB_N-th consecutive qualifying valid sample. deb_cnt then clears.
  - Invalid cycles (sensor_valid=0) hold deb_cnt.
- Timeout:
  - to_cnt clears on each sensor_valid and counts otherwise.
  - When to_cnt reaches TIMEOUT-1 with no valid sample, enter FAULT on the next edge.
- Invalid code: a valid sample equal to -2^(SENSOR_W-1) enters FAULT immediately, with no debounce.
- FAULT:
  - fault_o=1 and crs_o loads DUTY_MAX on the same edge (no ramp).
  - Exit on the first valid non-invalid-code sample: go to L3, fault_o=0, deb_cnt=0, target DUTY3, ramp down normally.
- Ramp:
  - A free-running prescaler pulses once every RAMP_DIV cycles.
  - On a pulse, crs_o moves 1 toward target. crs_o never overshoots.
  - The prescaler runs continuously and is not realigned on a target change.
  - ramping_o is combinational: (crs_o != target).
- en=0:
  - Level is forced OFF synchronously, fault_o cleared, deb_cnt and to_cnt held at 0.
  - crs_o ramps to 0.
  - Timeout cannot fire while disabled.
- en rising: resume from OFF with fresh counters.
- Simultaneous events:
  - Priority: en=0 > invalid code > timeout > debounced step.
  - A valid sample on the timeout cycle clears to_cnt, so no fault is raised.
- Mid-operation reset: asynchronous return to reset values, including a crs_o mid-ramp.

Test Plan:
1. Reset, en=1, sensor=36 valid every cycle -> level_o 1 after 3rd sample edge; crs_o 0->4 in steps every 4 cycles, ramping_o low once crs_o=4.
2. In L1, samples 41,41,30,41,41,41 -> no step until the final 41 (debounce restarted); then level 2, crs_o ramps 4->6.
3. In L2, hold sensor=38 valid -> stays L2 indefinitely (hysteresis band 35..45); then 34 x3 -> L1, crs_o ramps down to 4.
4. In L1, sensor_valid=0 for 1000 cycles -> FAULT, fault_o=1, crs_o=15 the same edge; one valid 30 -> level 3, fault_o=0, crs_o ramps 15->8.
5. Valid sample -128 in OFF -> immediate FAULT, crs_o=15; en deasserted -> level 0, fault_o 0, crs_o ramps to 0 (15 steps x 4 cycles).
6. rstn asserted mid-ramp (crs_o=5, level 2) -> all outputs 0 asynchronously; released with sensor=20 -> remains OFF.
